// File: rtl/microsequencer.sv
// Next-address stage of the control unit: holds the micro-PC that indexes the
// microstore ROM and selects the following address from the current
// microinstruction's next-state mode, a selected status condition, the
// instruction-decoder entry address, a one-deep return register and a
// memory-wait counter that traps to TRAP_ADDR after WAIT_MAX false cycles.
module microsequencer #(
  parameter int                 ADDR_W     = 7,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0]  TRAP_ADDR  = {ADDR_W{1'b1}},
  parameter int                 WAIT_MAX   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_en,
  input  logic [2:0]        ns,
  input  logic [ADDR_W-1:0] cr,
  input  logic              inv,
  input  logic [1:0]        cond_sel,
  input  logic [3:0]        cond_in,
  input  logic [ADDR_W-1:0] decoder_addr,
  output logic [ADDR_W-1:0] index,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              waiting,
  output logic              mem_timeout
);

  // Next-state modes carried in the microinstruction.
  localparam logic [2:0] NS_INCR   = 3'd0;
  localparam logic [2:0] NS_JUMP   = 3'd1;
  localparam logic [2:0] NS_DECODE = 3'd2;
  localparam logic [2:0] NS_BRANCH = 3'd3;
  localparam logic [2:0] NS_BRDEC  = 3'd4;
  localparam logic [2:0] NS_WAIT   = 3'd5;
  localparam logic [2:0] NS_CALL   = 3'd6;
  localparam logic [2:0] NS_RET    = 3'd7;

  // The counter only ever has to reach WAIT_MAX-1 before it traps and clears.
  localparam int               CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  logic [ADDR_W-1:0] index_reg, index_next;
  logic [ADDR_W-1:0] ret_reg, ret_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic              timeout_reg, timeout_next;
  logic              cond;
  logic [ADDR_W-1:0] inc;

  // Selected status condition and wrapping successor address.
  always_comb begin
    cond = cond_in[cond_sel] ^ inv;
    inc  = index_reg + ADDR_W'(1);
  end

  // Next-address selection; with step_en low every register simply holds.
  always_comb begin
    index_next    = index_reg;
    ret_next      = ret_reg;
    wait_cnt_next = wait_cnt_reg;
    timeout_next  = timeout_reg;
    if (step_en) begin
      // Any non-WAIT mode abandons a partially counted wait.
      wait_cnt_next = '0;
      case (ns)
        NS_INCR:   index_next = inc;
        NS_JUMP:   index_next = cr;
        NS_DECODE: index_next = decoder_addr;
        NS_BRANCH: index_next = cond ? cr : inc;
        NS_BRDEC:  index_next = cond ? cr : decoder_addr;
        NS_WAIT: begin
          if (cond) begin
            index_next = inc;
          end else if (wait_cnt_reg != CNT_LAST) begin
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
          end else begin
            // Memory never answered: trap; the flag stays set until reset.
            index_next   = TRAP_ADDR;
            timeout_next = 1'b1;
          end
        end
        NS_CALL: begin
          ret_next   = inc;
          index_next = cr;
        end
        NS_RET:    index_next = ret_reg;
        default:   index_next = inc;
      endcase
    end
  end

  // State registers; reset overrides stepping and every mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      index_reg    <= RESET_ADDR;
      ret_reg      <= '0;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      index_reg    <= index_next;
      ret_reg      <= ret_next;
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  // Outputs: registered state plus the combinational stall indication.
  always_comb begin
    index       = index_reg;
    ret_addr    = ret_reg;
    mem_timeout = timeout_reg;
    waiting     = (ns == NS_WAIT) && !cond;
  end

endmodule

// File: tb/tb_microsequencer.sv
// Directed test of the microsequencer against a behavioural next-address model
// plus hand-computed literal expectations for the documented scenarios.
module tb_microsequencer;

  localparam logic [2:0] INCR = 3'd0, JUMP = 3'd1, DEC = 3'd2, BR = 3'd3;
  localparam logic [2:0] BRD = 3'd4, WT = 3'd5, CALL = 3'd6, RET = 3'd7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       step_en = 1'b1;
  logic [2:0] ns = JUMP;
  logic [6:0] cr = 7'd50;
  logic       inv = 1'b0;
  logic [1:0] cond_sel = 2'd0;
  logic [3:0] cond_in = 4'd0;
  logic [6:0] decoder_addr = 7'd0;
  logic [6:0] index;
  logic [6:0] ret_addr;
  logic       waiting;
  logic       mem_timeout;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int  m_idx = 0, m_ret = 0, m_wcnt = 0;
  bit  m_to = 0;
  bit  model_valid = 0;

  microsequencer dut (
    .clk(clk), .reset(reset), .step_en(step_en), .ns(ns), .cr(cr),
    .inv(inv), .cond_sel(cond_sel), .cond_in(cond_in),
    .decoder_addr(decoder_addr), .index(index), .ret_addr(ret_addr),
    .waiting(waiting), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_cond();
    logic [3:0] ci;
    ci = cond_in;
    return ci[cond_sel] ^ inv;
  endfunction

  // Advance the model by one clock edge using the rules for each mode.
  task automatic model_edge();
    int  inc;
    bit  c;
    c   = model_cond();
    inc = (m_idx + 1) % 128;
    if (reset) begin
      m_idx = 0; m_ret = 0; m_to = 0; m_wcnt = 0;
    end else if (step_en) begin
      if (ns != WT) m_wcnt = 0;
      case (ns)
        INCR: m_idx = inc;
        JUMP: m_idx = cr;
        DEC:  m_idx = decoder_addr;
        BR:   m_idx = c ? int'(cr) : inc;
        BRD:  m_idx = c ? int'(cr) : int'(decoder_addr);
        WT: begin
          if (c) begin
            m_idx = inc; m_wcnt = 0;
          end else if (m_wcnt < 14) begin
            m_wcnt++;
          end else begin
            m_idx = 127; m_to = 1; m_wcnt = 0;
          end
        end
        CALL: begin m_ret = inc; m_idx = cr; end
        default: m_idx = m_ret;
      endcase
    end
  endtask

  // Apply one cycle of inputs, clock it, and update the model.
  task automatic st(input logic r, input logic se, input logic [2:0] n,
                    input logic [6:0] a, input logic iv, input logic [1:0] cs,
                    input logic [3:0] ci, input logic [6:0] da);
    @(negedge clk);
    #1;
    reset = r; step_en = se; ns = n; cr = a; inv = iv;
    cond_sel = cs; cond_in = ci; decoder_addr = da;
    @(posedge clk);
    model_edge();
    model_valid = 1;
    #2;
    $display("cyc r=%0b se=%0b ns=%0d cr=%0d c=%0b -> index=%0d ret=%0d to=%0b wait=%0b",
             r, se, n, a, model_cond(), index, ret_addr, mem_timeout, waiting);
  endtask

  task automatic go(input logic [2:0] n, input logic [6:0] a);
    st(1'b0, 1'b1, n, a, 1'b0, 2'd0, 4'd0, 7'd0);
  endtask

  task automatic wt(input logic moc, input int cycles);
    for (int k = 0; k < cycles; k++)
      st(1'b0, 1'b1, WT, 7'd0, 1'b0, 2'd0, {3'b000, moc}, 7'd0);
  endtask

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("index", int'(index), m_idx);
      check("ret_addr", int'(ret_addr), m_ret);
      check("mem_timeout", int'(mem_timeout), int'(m_to));
      check("waiting", int'(waiting), int'((ns == WT) && !model_cond()));
    end
  end

  initial begin
    // 1. Reset for two cycles with a JUMP presented, then count up.
    st(1'b1, 1'b1, JUMP, 7'd50, 1'b0, 2'd0, 4'd0, 7'd0);
    st(1'b1, 1'b1, JUMP, 7'd50, 1'b0, 2'd0, 4'd0, 7'd0);
    check("lit_reset_index", int'(index), 0);
    check("lit_reset_ret", int'(ret_addr), 0);
    check("lit_reset_to", int'(mem_timeout), 0);
    for (int k = 1; k <= 3; k++) begin
      go(INCR, 7'd0);
      check("lit_incr", int'(index), k);
    end

    // 2. Wrap at 127 for INCR and CALL.
    go(JUMP, 7'd127);
    go(INCR, 7'd0);
    check("lit_wrap", int'(index), 0);
    go(JUMP, 7'd127);
    go(CALL, 7'd10);
    check("lit_call127_idx", int'(index), 10);
    check("lit_call127_ret", int'(ret_addr), 0);

    // 3. Conditional branches on each condition select.
    go(JUMP, 7'd5);
    st(1'b0, 1'b1, BR, 7'd85, 1'b0, 2'd1, 4'b0010, 7'd0);
    check("lit_br_taken", int'(index), 85);
    go(JUMP, 7'd5);
    st(1'b0, 1'b1, BR, 7'd85, 1'b1, 2'd1, 4'b0010, 7'd0);
    check("lit_br_inv", int'(index), 6);
    st(1'b0, 1'b1, BRD, 7'd85, 1'b1, 2'd1, 4'b0010, 7'd40);
    check("lit_brdec", int'(index), 40);
    go(JUMP, 7'd5);
    st(1'b0, 1'b1, BR, 7'd70, 1'b0, 2'd2, 4'b0100, 7'd0);
    st(1'b0, 1'b1, BR, 7'd99, 1'b0, 2'd3, 4'b0111, 7'd0);
    check("lit_br_sel3", int'(index), 71);
    st(1'b0, 1'b1, BRD, 7'd12, 1'b0, 2'd3, 4'b1000, 7'd40);
    check("lit_brdec_taken", int'(index), 12);
    st(1'b0, 1'b1, DEC, 7'd0, 1'b0, 2'd0, 4'd0, 7'd77);
    check("lit_decode", int'(index), 77);

    // 4. Call / return, and overwrite of a pending return.
    go(JUMP, 7'd20);
    go(CALL, 7'd90);
    check("lit_call_idx", int'(index), 90);
    check("lit_call_ret", int'(ret_addr), 21);
    go(RET, 7'd0);
    check("lit_ret", int'(index), 21);
    go(JUMP, 7'd90);
    go(CALL, 7'd60);
    check("lit_call2_ret", int'(ret_addr), 91);

    // 5. Memory wait: short stall, then a full timeout.
    wt(1'b0, 3);
    check("lit_wait_hold", int'(index), 60);
    check("lit_waiting", int'(waiting), 1);
    wt(1'b1, 1);
    check("lit_wait_done", int'(index), 61);
    wt(1'b0, 14);
    check("lit_wait14", int'(index), 61);
    check("lit_wait14_to", int'(mem_timeout), 0);
    wt(1'b0, 1);
    check("lit_trap", int'(index), 127);
    check("lit_trap_to", int'(mem_timeout), 1);

    // 6. Freeze mid-wait: counter must resume, not restart.
    go(INCR, 7'd0);
    wt(1'b0, 5);
    for (int k = 0; k < 4; k++)
      st(1'b0, 1'b0, JUMP, 7'd33, 1'b0, 2'd0, 4'd0, 7'd0);
    check("lit_freeze", int'(index), 0);
    wt(1'b0, 9);
    check("lit_resume9", int'(index), 0);
    wt(1'b0, 1);
    check("lit_retrap", int'(index), 127);

    // Reset mid-wait with step_en low discards the count and the flag.
    go(INCR, 7'd0);
    wt(1'b0, 7);
    st(1'b1, 1'b0, JUMP, 7'd33, 1'b0, 2'd0, 4'd0, 7'd0);
    check("lit_reset_hold", int'(index), 0);
    check("lit_reset_to2", int'(mem_timeout), 0);
    wt(1'b0, 14);
    check("lit_post_reset14", int'(index), 0);
    wt(1'b0, 1);
    check("lit_post_reset_trap", int'(index), 127);

    // A non-WAIT step clears a partial count.
    go(INCR, 7'd0);
    wt(1'b0, 10);
    go(INCR, 7'd0);
    wt(1'b0, 14);
    check("lit_clear14", int'(index), 1);
    wt(1'b0, 1);
    check("lit_clear_trap", int'(index), 127);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
